// File: rtl/ifft_frame_sink.sv
// ifft_frame_sink: re-times the CE-gated IFFT output into a valid/ready stream with frame tags and error flags
module ifft_frame_sink #(
  parameter int IWIDTH = 16,
  parameter int LGSIZE = 11,
  parameter int LGFIFO = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic                  i_sync,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*IWIDTH-1:0]   o_data,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_overflow,
  output logic                  o_sync_err,
  output logic [15:0]           o_frame_count
);
  localparam int DW = 2*IWIDTH;
  localparam int DEPTH = 1 << LGFIFO;
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state_q, state_d;
  logic [LGSIZE-1:0]   idx_q, idx_d, eidx;
  logic [LGFIFO-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LGFIFO:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic [15:0]         fc_q, fc_d;
  logic [DW+1:0]       mem [DEPTH];
  logic [DW+1:0]       head;
  logic                attempt, pop, wr_ok;
  // Framing state, FIFO bookkeeping and sticky flags; a sync always restarts the frame at index 0
  always_comb begin
    head    = mem[rptr_q];
    pop     = (cnt_q != '0) && i_ready;
    attempt = i_ce && (state_q == RUN || i_sync);
    wr_ok   = attempt && (cnt_q != (LGFIFO+1)'(DEPTH) || pop);
    eidx    = i_sync ? '0 : idx_q;
    state_d = attempt ? (wr_ok ? RUN : IDLE) : state_q;
    idx_d   = attempt ? (wr_ok ? eidx + 1'b1 : '0) : idx_q;
    wptr_d  = wptr_q + LGFIFO'(wr_ok);
    rptr_d  = rptr_q + LGFIFO'(pop);
    cnt_d   = cnt_q + (LGFIFO+1)'(wr_ok) - (LGFIFO+1)'(pop);
    ovf_d   = ovf_q | (attempt & ~wr_ok);
    err_d   = err_q | (i_ce & i_sync & (state_q == RUN) & (idx_q != '0));
    fc_d    = fc_q + 16'(pop & head[DW]);
  end
  // State registers; reset empties the FIFO at once by clearing the pointers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end
  // FIFO storage: entry is {first, last, data}; when full and popping, the slot being read is the one rewritten
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr_q] <= {eidx == '0, eidx == '1, i_sample};
  end
  assign o_valid       = cnt_q != '0;
  assign o_data        = o_valid ? head[DW-1:0] : '0;
  assign o_first       = o_valid & head[DW+1];
  assign o_last        = o_valid & head[DW];
  assign o_overflow    = ovf_q;
  assign o_sync_err    = err_q;
  assign o_frame_count = fc_q;
endmodule

// File: tb/tb_ifft_frame_sink.sv
// tb_ifft_frame_sink: checks two FIFO depths against a queue-level reference model
module tb_ifft_frame_sink;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1, i_ce = 1'b0, i_sync = 1'b0, i_ready = 1'b0;
  logic [31:0] i_sample = '0;
  logic        vld [2], fst [2], lst [2], ovf [2], serr [2];
  logic [31:0] dat [2];
  logic [15:0] fc [2];
  int n_asrt = 0, n_fail = 0;
  logic        mf [2][32], ml [2][32];
  logic [31:0] md [2][32];
  int          mh [2], mc [2], midx [2], mfc [2];
  bit          mrun [2], movf [2], merr [2];

  always #5 i_clk = ~i_clk;

  ifft_frame_sink #(.IWIDTH(16), .LGSIZE(3), .LGFIFO(2)) u_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample), .i_sync(i_sync),
    .o_valid(vld[0]), .i_ready(i_ready), .o_data(dat[0]), .o_first(fst[0]), .o_last(lst[0]),
    .o_overflow(ovf[0]), .o_sync_err(serr[0]), .o_frame_count(fc[0]));
  ifft_frame_sink #(.IWIDTH(16), .LGSIZE(3), .LGFIFO(5)) u_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample), .i_sync(i_sync),
    .o_valid(vld[1]), .i_ready(i_ready), .o_data(dat[1]), .o_first(fst[1]), .o_last(lst[1]),
    .o_overflow(ovf[1]), .o_sync_err(serr[1]), .o_frame_count(fc[1]));

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int e, slot;
      if (i_reset) begin
        mh[k] = 0; mc[k] = 0; midx[k] = 0; mfc[k] = 0;
        mrun[k] = 0; movf[k] = 0; merr[k] = 0;
      end else begin
        if (mc[k] > 0 && i_ready) begin
          if (ml[k][mh[k]]) mfc[k] = (mfc[k] + 1) % 65536;
          mh[k] = (mh[k] + 1) % 32;
          mc[k]--;
        end
        if (i_ce && (mrun[k] || i_sync)) begin
          e = i_sync ? 0 : midx[k];
          if (i_sync && mrun[k] && midx[k] != 0) merr[k] = 1;
          if (mc[k] < (k == 0 ? 4 : 32)) begin
            slot = (mh[k] + mc[k]) % 32;
            mf[k][slot] = (e == 0);
            ml[k][slot] = (e == 7);
            md[k][slot] = i_sample;
            mc[k]++;
            midx[k] = (e + 1) % 8;
            mrun[k] = 1;
          end else begin
            movf[k] = 1;
            mrun[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit ne;
      ne = mc[k] > 0;
      chk("valid", k, 32'(vld[k]), 32'(ne));
      chk("data", k, dat[k], ne ? md[k][mh[k]] : 32'h0);
      chk("first", k, 32'(fst[k]), ne ? 32'(mf[k][mh[k]]) : 32'h0);
      chk("last", k, 32'(lst[k]), ne ? 32'(ml[k][mh[k]]) : 32'h0);
      chk("overflow", k, 32'(ovf[k]), 32'(movf[k]));
      chk("sync_err", k, 32'(serr[k]), 32'(merr[k]));
      chk("frame_count", k, 32'(fc[k]), 32'(mfc[k]));
    end
  endtask

  task automatic step(bit ce, bit sy, logic [31:0] d, bit rdy, bit r);
    i_ce = ce; i_sync = sy; i_sample = d; i_ready = rdy; i_reset = r;
    @(posedge i_clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    step(0, 0, 0, 1, 1);
    step(1, 1, 32'h1234, 1, 1);
    chk("reset_valid", 0, 32'(vld[0]), 0);
    for (int i = 0; i < 4; i++) step(1, 0, $urandom, 1, 0);
    for (int i = 0; i < 8; i++) step(1, i == 0, 32'h00010002 + 32'(i) * 32'h00010001, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("basic_fc", 0, 32'(fc[0]), 1);
    chk("basic_ovf", 0, 32'(ovf[0]), 0);
    for (int i = 0; i < 24; i++) step(1, i == 0, $urandom, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("b2b_fc", 0, 32'(fc[0]), 4);
    for (int i = 0; i < 96; i++) step(i % 2 == 0, i == 0, $urandom, i % 3 == 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0);
    chk("bp_ovf", 1, 32'(ovf[1]), 0);
    chk("bp_fc", 1, 32'(fc[1]), 10);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, i == 0, $urandom, 0, 0);
    chk("ovf_flag", 0, 32'(ovf[0]), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    chk("ovf_fc", 0, 32'(fc[0]), 0);
    for (int i = 0; i < 8; i++) step(1, i == 0, $urandom, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("ovf_next_fc", 0, 32'(fc[0]), 1);
    for (int i = 0; i < 16; i++) step(1, i == 0 || i == 5, $urandom, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("serr_flag", 0, 32'(serr[0]), 1);
    chk("serr_fc", 0, 32'(fc[0]), 2);
    for (int i = 0; i < 3; i++) step(1, i == 0, $urandom, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("midrst_valid", 0, 32'(vld[0]), 0);
    chk("midrst_fc", 0, 32'(fc[0]), 0);
    for (int i = 0; i < 5; i++) step(1, 0, $urandom, 1, 0);
    chk("midrst_ignore", 0, 32'(vld[0]), 0);
    for (int i = 0; i < 8; i++) step(1, i == 0, $urandom, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, $urandom % 12 == 0, $urandom, $urandom % 3 != 0, $urandom % 150 == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/ifft_frame_sink.md
Name: ifft_frame_sink

Overview:
Downstream consumer of the 2048-point IFFT core's CE-gated output stream (sample bus plus first-sample sync).
- Re-times that stream into a valid/ready stream through a small first-word-fall-through FIFO.
- Tags first and last samples of each frame.
- Flags frame-alignment errors and overflow.
- Feeds the DMA/host-side packetiser, which may stall.

Parameters:
IWIDTH, 16, bits per real/imag component; sample bus is 2*IWIDTH (real high, imag low)
LGSIZE, 11, log2 of frame length (2048 samples)
LGFIFO, 5, log2 of FIFO depth (32 entries)

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_ce  input  1  upstream sample strobe; one sample per asserted cycle
i_sample  input  2*IWIDTH  IFFT output sample
i_sync  input  1  high with the first sample of a frame (qualified by i_ce)
o_valid  output  1  o_data/o_first/o_last valid
i_ready  input  1  downstream accepts when o_valid && i_ready
o_data  output  2*IWIDTH  sample, unmodified
o_first  output  1  sample index 0 of frame
o_last  output  1  sample index 2^LGSIZE-1 of frame
o_overflow  output  1  sticky: a sample was dropped due to full FIFO
o_sync_err  output  1  sticky: i_sync seen at nonzero index
o_frame_count  output  16  frames fully delivered (o_last handshakes), wraps at 2^16

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk. All outputs 0, FIFO empty, state IDLE, index counter 0. Reset mid-frame discards FIFO contents immediately. o_valid is 0 the cycle after reset.
- State IDLE:
  - i_ce without i_sync: sample discarded.
  - i_ce && i_sync: write sample at index 0 (first=1), idx<=1, go RUN.
- State RUN, on each i_ce:
  - Write sample with first=(idx==0), last=(idx==2^LGSIZE-1).
  - idx<=idx+1, wrapping to 0 after 2^LGSIZE-1; frames continue back-to-back without further i_sync.
- i_sync in RUN with idx==0: normal, no error.
- i_sync in RUN with idx!=0: set o_sync_err. Write sample as index 0 (first=1), idx<=1. The truncated previous frame gets no o_last.
- i_sync without i_ce: ignored.
- FIFO entry: {first, last, data}, width 2*IWIDTH+2, depth 2^LGFIFO.
- Write permitted if not full, or if a pop occurs the same cycle (full && pop && write leaves count unchanged).
- Overflow (write attempted, not permitted):
  - Sample dropped; o_overflow set.
  - State -> IDLE; rest of frame discarded until next i_sync.
  - Entries already queued are still delivered.
- Output is first-word-fall-through:
  - o_valid = FIFO non-empty; o_data/o_first/o_last reflect head entry.
  - Write at cycle N into empty FIFO -> o_valid at N+1.
  - Pop on o_valid && i_ready.
  - Outputs stable while o_valid && !i_ready.
- o_frame_count increments on each handshake with o_last=1.
- Sticky flags clear only on i_reset.
- Simultaneous push and pop into an empty FIFO: the push is visible at N+1; no bypass in the same cycle.

Test Plan:
- Basic frame (LGSIZE=3, LGFIFO=2, i_ready=1, i_ce every cycle): 4 junk samples, then i_sync with samples 0x00010002..0x00080009 -> outputs in order with 1-cycle latency; o_first on 0x00010002, o_last on 0x00080009; o_frame_count=1; flags 0.
- Back-to-back frames: 3 consecutive frames with i_sync only on the first -> 24 outputs, o_first/o_last every 8th, o_frame_count=3.
- Backpressure with CE gaps: i_ce 50% duty, i_ready low for 2 of every 3 cycles, LGFIFO=5 -> no loss, order preserved, o_overflow=0, data held stable during stalls.
- Overflow (LGFIFO=2): i_ready=0, sync plus 8 samples -> first 4 queued, 5th dropped, o_overflow=1, rest ignored. Raise i_ready -> exactly 4 words out with no o_last. Next i_sync frame is delivered complete.
- Sync error: i_sync at index 5 of a frame -> o_sync_err=1; that sample is emitted with o_first=1; next o_last falls 7 samples later.
- Reset mid-frame with 3 entries queued: i_reset one cycle -> o_valid=0 the next cycle, o_frame_count=0, flags 0; samples ignored until the next i_sync.
